// File: rtl/mips_control_register_scoreboard.sv
// mips_control_register_scoreboard
// Tracks outstanding register-file writes between issue and writeback.
// Each architectural register 1..31 has a small counter of writes that have
// issued but not yet retired; issue is held while a source has pending writes
// or the destination counter is full. Register 0 is never tracked.
// Optional feature macro: MIPS_CONTROL_REGISTER_SCOREBOARD_BYPASS_EN
//   When defined, a source whose single outstanding write retires in the
//   current cycle is not a hazard (writeback data is forwarded).
module mips_control_register_scoreboard #(
  parameter int PENDING_W = 2,
  parameter int STALL_W   = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               issue_valid,
  output logic               issue_ready,
  input  logic [4:0]         issue_rs_addr,
  input  logic               issue_rs_use,
  input  logic [4:0]         issue_rt_addr,
  input  logic               issue_rt_use,
  input  logic [4:0]         issue_wr_addr,
  input  logic               issue_wr_en,
  input  logic               retire_valid,
  input  logic [4:0]         retire_addr,
  input  logic               flush,
  output logic               busy,
  output logic               underflow,
  output logic [STALL_W-1:0] stall_cycles
);

  localparam logic [PENDING_W-1:0] CNT_MAX  = '1;
  localparam logic [PENDING_W-1:0] CNT_ONE  = PENDING_W'(1);
  localparam logic [STALL_W-1:0]   STALL_MAX = '1;

  // Per-register outstanding-write counters; entry 0 is held at zero.
  logic [PENDING_W-1:0] r_cnt      [32];
  logic [PENDING_W-1:0] w_cnt_next [32];

  logic               r_busy;
  logic               r_underflow;
  logic [STALL_W-1:0] r_stall;

  logic [PENDING_W-1:0] w_rs_cnt;
  logic [PENDING_W-1:0] w_rt_cnt;
  logic [PENDING_W-1:0] w_wr_cnt;
  logic [PENDING_W-1:0] w_ret_cnt;
  logic                 w_rs_bypass;
  logic                 w_rt_bypass;
  logic                 w_hazard_rs;
  logic                 w_hazard_rt;
  logic                 w_wr_retiring;
  logic                 w_full;
  logic                 w_ready;
  logic                 w_fire;
  logic                 w_retire_zero;
  logic                 w_stall_evt;
  logic                 w_any_pending;

  assign w_rs_cnt  = r_cnt[issue_rs_addr];
  assign w_rt_cnt  = r_cnt[issue_rt_addr];
  assign w_wr_cnt  = r_cnt[issue_wr_addr];
  assign w_ret_cnt = r_cnt[retire_addr];

`ifdef MIPS_CONTROL_REGISTER_SCOREBOARD_BYPASS_EN
  // A source whose last outstanding write is retiring now is forwarded.
  assign w_rs_bypass = retire_valid && (retire_addr == issue_rs_addr) && (w_rs_cnt == CNT_ONE);
  assign w_rt_bypass = retire_valid && (retire_addr == issue_rt_addr) && (w_rt_cnt == CNT_ONE);
`else
  // Without forwarding a source waits until its counter has reached zero.
  assign w_rs_bypass = 1'b0;
  assign w_rt_bypass = 1'b0;
`endif

  assign w_hazard_rs = issue_rs_use && (issue_rs_addr != 5'd0) &&
                       (w_rs_cnt != '0) && !w_rs_bypass;
  assign w_hazard_rt = issue_rt_use && (issue_rt_addr != 5'd0) &&
                       (w_rt_cnt != '0) && !w_rt_bypass;

  // A full destination counter can still accept a write if one retires now.
  assign w_wr_retiring = retire_valid && (retire_addr == issue_wr_addr);
  assign w_full        = issue_wr_en && (issue_wr_addr != 5'd0) &&
                         (w_wr_cnt == CNT_MAX) && !w_wr_retiring;

  assign w_ready     = !w_hazard_rs && !w_hazard_rt && !w_full && !flush;
  assign issue_ready = w_ready;
  assign w_fire      = issue_valid && w_ready;

  // Retiring a register with nothing outstanding is a protocol error; flush masks it.
  assign w_retire_zero = retire_valid && (retire_addr != 5'd0) &&
                         (w_ret_cnt == '0) && !flush;

  assign w_stall_evt = issue_valid && !w_ready;

  // Next-state counter per register: issue increments, retire decrements,
  // both together cancel, flush clears.
  generate
    for (genvar gi = 0; gi < 32; gi++) begin : g_cnt
      if (gi == 0) begin : g_zero
        assign w_cnt_next[gi] = '0;
      end else begin : g_reg
        logic w_inc;
        logic w_dec;
        assign w_inc = w_fire && issue_wr_en && (issue_wr_addr == 5'(gi));
        assign w_dec = retire_valid && (retire_addr == 5'(gi)) && (r_cnt[gi] != '0);
        assign w_cnt_next[gi] = flush            ? '0 :
                                (w_inc && !w_dec) ? r_cnt[gi] + CNT_ONE :
                                (w_dec && !w_inc) ? r_cnt[gi] - CNT_ONE :
                                                    r_cnt[gi];
      end
    end
  endgenerate

  // Busy reflects whether any counter will be non-zero after this edge.
  always_comb begin
    w_any_pending = 1'b0;
    for (int k = 1; k < 32; k++) begin
      w_any_pending = w_any_pending | (w_cnt_next[k] != '0);
    end
  end

  // Counter array update.
  always_ff @(posedge clock) begin
    for (int k = 0; k < 32; k++) begin
      if (reset) r_cnt[k] <= '0;
      else       r_cnt[k] <= w_cnt_next[k];
    end
  end

  // Status flags: busy, sticky underflow and saturating stall counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_busy      <= 1'b0;
      r_underflow <= 1'b0;
      r_stall     <= '0;
    end else begin
      r_busy <= w_any_pending;
      if (w_retire_zero) r_underflow <= 1'b1;
      if (w_stall_evt && (r_stall != STALL_MAX)) r_stall <= r_stall + STALL_W'(1);
    end
  end

  assign busy         = r_busy;
  assign underflow    = r_underflow;
  assign stall_cycles = r_stall;

endmodule

// File: tb/tb_mips_control_register_scoreboard.sv
// Testbench for mips_control_register_scoreboard: directed scenarios followed
// by random traffic, checked against a counting model of pending writes.
// Honours MIPS_CONTROL_REGISTER_SCOREBOARD_BYPASS_EN the same way as the design.
module tb_mips_control_register_scoreboard;

`ifdef MIPS_CONTROL_REGISTER_SCOREBOARD_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam int MAXC     = 3;
  localparam int STALLMAX = 65535;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        issue_valid = 1'b0;
  logic        issue_ready;
  logic [4:0]  issue_rs_addr = '0;
  logic        issue_rs_use = 1'b0;
  logic [4:0]  issue_rt_addr = '0;
  logic        issue_rt_use = 1'b0;
  logic [4:0]  issue_wr_addr = '0;
  logic        issue_wr_en = 1'b0;
  logic        retire_valid = 1'b0;
  logic [4:0]  retire_addr = '0;
  logic        flush = 1'b0;
  logic        busy;
  logic        underflow;
  logic [15:0] stall_cycles;

  int errors = 0;
  int checks = 0;

  // Model: number of unretired writes per register, plus status.
  int m_cnt [32];
  int m_uf;
  int m_stall;

  mips_control_register_scoreboard #(.PENDING_W(2), .STALL_W(16)) dut (
    .clock         (clock),
    .reset         (reset),
    .issue_valid   (issue_valid),
    .issue_ready   (issue_ready),
    .issue_rs_addr (issue_rs_addr),
    .issue_rs_use  (issue_rs_use),
    .issue_rt_addr (issue_rt_addr),
    .issue_rt_use  (issue_rt_use),
    .issue_wr_addr (issue_wr_addr),
    .issue_wr_en   (issue_wr_en),
    .retire_valid  (retire_valid),
    .retire_addr   (retire_addr),
    .flush         (flush),
    .busy          (busy),
    .underflow     (underflow),
    .stall_cycles  (stall_cycles)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic void m_clear();
    for (int k = 0; k < 32; k++) m_cnt[k] = 0;
    m_uf    = 0;
    m_stall = 0;
  endfunction

  function automatic bit m_src_stall(logic [4:0] a, bit use_it, bit rv, logic [4:0] ra);
    if (!use_it || a == 5'd0 || m_cnt[a] == 0) return 1'b0;
    if (BYP && m_cnt[a] == 1 && rv && ra == a) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit m_busy();
    for (int k = 1; k < 32; k++) if (m_cnt[k] > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic do_reset(input int n);
    reset = 1'b1;
    issue_valid = 1'b0; issue_rs_use = 1'b0; issue_rt_use = 1'b0;
    issue_wr_en = 1'b0; retire_valid = 1'b0; flush = 1'b0;
    repeat (n) @(posedge clock);
    #1;
    reset = 1'b0;
    m_clear();
  endtask

  // One cycle: drive, check combinational ready, clock, check registered status.
  task automatic step(input bit v, input logic [4:0] rs, input bit ru,
                      input logic [4:0] rt, input bit tu,
                      input logic [4:0] wr, input bit we,
                      input bit rv, input logic [4:0] ra, input bit fl);
    bit exp_rdy;
    int pre [32];
    issue_valid = v; issue_rs_addr = rs; issue_rs_use = ru;
    issue_rt_addr = rt; issue_rt_use = tu;
    issue_wr_addr = wr; issue_wr_en = we;
    retire_valid = rv; retire_addr = ra; flush = fl;
    #2;
    exp_rdy = !fl && !m_src_stall(rs, ru, rv, ra) && !m_src_stall(rt, tu, rv, ra) &&
              !(we && wr != 5'd0 && m_cnt[wr] == MAXC && !(rv && ra == wr));
    chk("issue_ready", {31'd0, issue_ready}, {31'd0, exp_rdy});
    @(posedge clock);
    if (fl) begin
      for (int k = 0; k < 32; k++) m_cnt[k] = 0;
    end else begin
      for (int k = 0; k < 32; k++) pre[k] = m_cnt[k];
      if (v && exp_rdy && we && wr != 5'd0) m_cnt[wr] = m_cnt[wr] + 1;
      if (rv && ra != 5'd0) begin
        if (pre[ra] > 0) m_cnt[ra] = m_cnt[ra] - 1;
        else             m_uf = 1;
      end
    end
    if (v && !exp_rdy && m_stall < STALLMAX) m_stall++;
    #1;
    chk("busy", {31'd0, busy}, {31'd0, m_busy()});
    chk("underflow", {31'd0, underflow}, m_uf);
    chk("stall_cycles", {16'd0, stall_cycles}, m_stall);
  endtask

  initial begin
    m_clear();

    // Power-on reset then idle.
    do_reset(3);
    #2;
    chk("reset_ready", {31'd0, issue_ready}, 32'd1);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_underflow", {31'd0, underflow}, 32'd0);
    chk("reset_stall", {16'd0, stall_cycles}, 32'd0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // RAW stall on $5.
    step(1, 0, 0, 0, 0, 5, 1, 0, 0, 0);
    step(1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 5, 1, 0, 0, 0, 0, 1, 5, 0);
    if (!BYP) step(1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
    chk("raw_stall_count", {16'd0, stall_cycles}, BYP ? 32'd2 : 32'd3);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Saturation of $7 at three outstanding writes.
    do_reset(1);
    step(1, 0, 0, 0, 0, 7, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0, 7, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0, 7, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0, 7, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0, 7, 1, 1, 7, 0);
    step(1, 0, 0, 0, 0, 7, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

    // Register zero: never tracked, never stalls, never underflows.
    step(1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    step(1, 0, 1, 0, 1, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    chk("zero_underflow", {31'd0, underflow}, 32'd0);

    // Simultaneous issue and retire on $4.
    step(1, 0, 0, 0, 0, 4, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0, 4, 1, 1, 4, 0);
    chk("simul_busy", {31'd0, busy}, 32'd1);
    step(0, 0, 0, 0, 0, 0, 0, 1, 4, 0);
    chk("simul_drained", {31'd0, busy}, 32'd0);

    // Underflow is sticky; flush clears outstanding writes.
    step(0, 0, 0, 0, 0, 0, 0, 1, 9, 0);
    chk("underflow_set", {31'd0, underflow}, 32'd1);
    step(1, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0, 2, 1, 0, 0, 0);
    step(1, 1, 1, 0, 0, 3, 1, 0, 0, 1);
    chk("flush_busy", {31'd0, busy}, 32'd0);
    step(1, 1, 1, 2, 1, 0, 0, 0, 0, 0);

    // Reset in the middle of pending state.
    step(1, 0, 0, 0, 0, 6, 1, 0, 0, 0);
    do_reset(1);
    step(1, 6, 1, 0, 0, 0, 0, 0, 0, 0);

    // Random traffic over a small register window to provoke conflicts.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) do_reset(1);
      step($urandom_range(0, 3) != 0,
           5'($urandom_range(0, 7)), $urandom_range(0, 1) != 0,
           5'($urandom_range(0, 7)), $urandom_range(0, 1) != 0,
           5'($urandom_range(0, 7)), $urandom_range(0, 2) != 0,
           $urandom_range(0, 9) < 4, 5'($urandom_range(0, 7)),
           $urandom_range(0, 24) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
